// File: rtl/led_scan_if.sv
// Display-side bundle for the LED scan transmitter: segment words and scan
// controls in, serial driver and digit-enable pins out.
interface led_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [16*NUM_DIGITS-1:0] seg_data;
  logic                     enable;
  logic                     blank;
  logic                     sclk;
  logic                     sdata;
  logic                     latch;
  logic [NUM_DIGITS-1:0]    digit_en;
  logic                     frame_done;

  modport master (
    output seg_data, enable, blank,
    input  sclk, sdata, latch, digit_en, frame_done
  );

  modport slave (
    input  seg_data, enable, blank,
    output sclk, sdata, latch, digit_en, frame_done
  );
endinterface

// File: rtl/led_scan_tx.sv
// Serialises one 16-bit segment word per digit into an external shift/latch
// LED driver and lights the digits one at a time in round-robin order.
module led_scan_tx #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 2,
  parameter int DWELL      = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  led_scan_if.slave  bus
);

  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIVW = $clog2(CLK_DIV + 1);
  localparam int DWW  = $clog2(DWELL + 1);

  localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [DIVW-1:0]       DIV_LAST   = DIVW'(CLK_DIV - 1);
  localparam logic [DWW-1:0]        DWELL_LAST = DWW'(DWELL - 1);
  localparam logic [DWW-1:0]        DWELL_PRE  = DWW'((DWELL >= 2) ? (DWELL - 2) : 0);
  localparam logic                  DWELL_ONE  = (DWELL == 1) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] DIGIT0     = NUM_DIGITS'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DWELL = 3'd4
  } state_t;

  state_t                state_r;
  logic [IW-1:0]         idx_r;
  logic [14:0]           shreg_r;
  logic [4:0]            bit_cnt_r;
  logic [DIVW-1:0]       div_cnt_r;
  logic [DWW-1:0]        dwell_cnt_r;
  logic                  sclk_r;
  logic                  sdata_r;
  logic                  latch_r;
  logic [NUM_DIGITS-1:0] den_r;
  logic                  frame_done_r;
  logic [15:0]           word_s;

  assign word_s = bus.seg_data[{idx_r, 4'b0000} +: 16];

  // Scan sequencer; every output is decided on the transition into the cycle it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      idx_r        <= '0;
      shreg_r      <= 15'h0000;
      bit_cnt_r    <= 5'd0;
      div_cnt_r    <= '0;
      dwell_cnt_r  <= '0;
      sclk_r       <= 1'b0;
      sdata_r      <= 1'b0;
      latch_r      <= 1'b0;
      den_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          sclk_r       <= 1'b0;
          sdata_r      <= 1'b0;
          latch_r      <= 1'b0;
          den_r        <= '0;
          frame_done_r <= 1'b0;
          state_r      <= bus.enable ? S_LOAD : S_IDLE;
        end
        S_LOAD: begin
          // MSB goes straight to sdata; the register holds the 15 bits still to send.
          shreg_r   <= word_s[14:0];
          sdata_r   <= word_s[15];
          sclk_r    <= 1'b0;
          bit_cnt_r <= 5'd16;
          div_cnt_r <= '0;
          state_r   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
            end else begin
              sclk_r    <= 1'b0;
              shreg_r   <= {shreg_r[13:0], 1'b0};
              bit_cnt_r <= bit_cnt_r - 5'd1;
              if (bit_cnt_r == 5'd1) begin
                sdata_r <= 1'b0;
                latch_r <= 1'b1;
                state_r <= S_LATCH;
              end else begin
                sdata_r <= shreg_r[14];
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIVW'(1);
          end
        end
        S_LATCH: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r    <= '0;
            latch_r      <= 1'b0;
            dwell_cnt_r  <= '0;
            den_r        <= DIGIT0 << idx_r;
            frame_done_r <= DWELL_ONE & (idx_r == LAST_IDX);
            state_r      <= S_DWELL;
          end else begin
            div_cnt_r <= div_cnt_r + DIVW'(1);
          end
        end
        S_DWELL: begin
          if (dwell_cnt_r == DWELL_LAST) begin
            den_r        <= '0;
            frame_done_r <= 1'b0;
            idx_r        <= (idx_r == LAST_IDX) ? '0 : (idx_r + IW'(1));
            state_r      <= bus.enable ? S_LOAD : S_IDLE;
          end else begin
            dwell_cnt_r  <= dwell_cnt_r + DWW'(1);
            frame_done_r <= (dwell_cnt_r == DWELL_PRE) && (idx_r == LAST_IDX);
          end
        end
        default: begin
          state_r      <= S_IDLE;
          sclk_r       <= 1'b0;
          sdata_r      <= 1'b0;
          latch_r      <= 1'b0;
          den_r        <= '0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sclk       = sclk_r;
  assign bus.sdata      = sdata_r;
  assign bus.latch      = latch_r;
  assign bus.frame_done = frame_done_r;
  // blank gates the registered enables directly so it takes effect in the same cycle.
  assign bus.digit_en   = den_r & {NUM_DIGITS{~bus.blank}};

endmodule

// File: tb/tb_led_scan_tx.sv
// Bench for led_scan_tx: a 4-digit and a 1-digit instance checked against a
// period/position reference model, a vector table and hand-written sequences.
module tb_led_scan_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        blank_a = 1'b0;
  logic        blank_b = 1'b0;
  logic [63:0] seg_a = 64'h0E70_1C70_0290_3AB1;
  logic [15:0] seg_b = 16'hA5C3;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  led_scan_if #(.NUM_DIGITS(4)) if_a ();
  led_scan_if #(.NUM_DIGITS(1)) if_b ();

  assign if_a.enable   = en;
  assign if_b.enable   = en;
  assign if_a.blank    = blank_a;
  assign if_b.blank    = blank_b;
  assign if_a.seg_data = seg_a;
  assign if_b.seg_data = seg_b;

  led_scan_tx #(.NUM_DIGITS(4), .CLK_DIV(2), .DWELL(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
  );
  led_scan_tx #(.NUM_DIGITS(1), .CLK_DIV(1), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a digit is a period of 1+33*CD+DW cycles, t is the position in it.
  typedef struct {
    bit          act;
    int          t;
    int          idx;
    logic [15:0] word;
  } mdl_t;

  typedef struct {
    logic       sclk;
    logic       sdata;
    logic       latch;
    logic       fd;
    logic [7:0] den;
  } out_t;

  localparam mdl_t MDL_RST = '{act: 1'b0, t: 0, idx: 0, word: 16'h0000};

  function automatic out_t mdl_out(mdl_t m, int n, int cd, int dw, logic blk);
    out_t o;
    int   b;
    o.sclk = 1'b0; o.sdata = 1'b0; o.latch = 1'b0; o.fd = 1'b0; o.den = 8'h00;
    if (m.act) begin
      if (m.t >= 1 && m.t <= 32 * cd) begin
        b       = (m.t - 1) / (2 * cd);
        o.sclk  = ((m.t - 1) % (2 * cd)) >= cd;
        o.sdata = m.word[15 - b];
      end else if (m.t > 32 * cd && m.t <= 33 * cd) begin
        o.latch = 1'b1;
      end else if (m.t > 33 * cd) begin
        if (!blk) o.den[m.idx] = 1'b1;
        o.fd = (m.t == 33 * cd + dw) && (m.idx == n - 1);
      end
    end
    return o;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int n, int cd, int dw, logic e, logic [127:0] seg);
    mdl_t r;
    int   p;
    r = m;
    p = 1 + 33 * cd + dw;
    if (!m.act) begin
      if (e) begin r.act = 1'b1; r.t = 0; end
    end else if (m.t == 0) begin
      r.word = seg[16 * m.idx +: 16];
      r.t    = 1;
    end else if (m.t == p - 1) begin
      r.idx = (m.idx + 1) % n;
      if (e) r.t = 0;
      else   r.act = 1'b0;
    end else begin
      r.t = m.t + 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] pk(out_t o);
    return {20'h0, o.sclk, o.sdata, o.latch, o.fd, o.den};
  endfunction

  mdl_t ma = MDL_RST;
  mdl_t mb = MDL_RST;

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    mdl_t ca;
    mdl_t cb;
    ca = rst_n ? ma : MDL_RST;
    cb = rst_n ? mb : MDL_RST;
    chk("mon_a", {20'h0, if_a.sclk, if_a.sdata, if_a.latch, if_a.frame_done, 4'h0, if_a.digit_en},
        pk(mdl_out(ca, 4, 2, 8, blank_a)));
    chk("mon_b", {20'h0, if_b.sclk, if_b.sdata, if_b.latch, if_b.frame_done, 7'h00, if_b.digit_en},
        pk(mdl_out(cb, 1, 1, 1, blank_b)));
    ma <= rst_n ? mdl_step(ca, 4, 2, 8, en, {64'h0, seg_a}) : MDL_RST;
    mb <= rst_n ? mdl_step(cb, 1, 1, 1, en, {112'h0, seg_b}) : MDL_RST;
  end

  typedef struct {
    int          cyc;
    logic        blank;
    logic [15:0] d1;
    logic        sclk;
    logic        sdata;
    logic        latch;
    logic [3:0]  den;
    logic        fd;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_a();
    return {24'h0, if_a.sclk, if_a.sdata, if_a.latch, if_a.digit_en, if_a.frame_done};
  endfunction

  function automatic logic [31:0] outs_b();
    return {28'h0, if_b.sclk, if_b.sdata, if_b.latch, if_b.digit_en[0] ^ if_b.frame_done ^ if_b.frame_done | if_b.frame_done};
  endfunction

  initial begin
    int cur;
    int last;
    int nfd;
    int nden;
    int nco;

    // Cycle numbers are relative to digit 0's LOAD; period is 75 cycles.
    tbl.push_back('{0,   1'b0, 16'h0290, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{3,   1'b0, 16'h0290, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{9,   1'b0, 16'h0290, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{11,  1'b0, 16'h0290, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{63,  1'b0, 16'h0290, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{65,  1'b1, 16'h0290, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0});
    tbl.push_back('{66,  1'b0, 16'h0290, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0});
    tbl.push_back('{67,  1'b0, 16'h0290, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0});
    tbl.push_back('{70,  1'b1, 16'h0290, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{74,  1'b0, 16'h0290, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0});
    tbl.push_back('{75,  1'b0, 16'h0290, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{80,  1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{102, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{106, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{142, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0});
    tbl.push_back('{165, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{217, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0});
    tbl.push_back('{224, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0});
    tbl.push_back('{244, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{292, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0});
    tbl.push_back('{298, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0});
    tbl.push_back('{299, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h8, 1'b1});
    tbl.push_back('{300, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{367, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0});

    tick();
    chk("reset_a", outs_a(), 32'h0);
    chk("reset_b", outs_b(), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    en = 1'b1;
    repeat (20) tick();
    // Asynchronous reset in the middle of the shift phase.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_a", outs_a(), 32'h0);
    chk("rst_async_b", outs_b(), 32'h0);
    en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("idle_hold_a", outs_a(), 32'h0);
    chk("idle_hold_b", outs_b(), 32'h0);
    tick();
    en = 1'b1;
    tick();
    cur = 0;

    foreach (tbl[i]) begin
      while (cur < tbl[i].cyc) begin tick(); cur++; end
      blank_a       = tbl[i].blank;
      seg_a[31:16]  = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("tbl_c%0d", tbl[i].cyc), outs_a(),
          {24'h0, tbl[i].sclk, tbl[i].sdata, tbl[i].latch, tbl[i].den, tbl[i].fd});
      #1 blank_a = 1'b0;
    end

    // Enable drop during digit 2's shift, then resume at digit 3.
    while (cur < 460) begin tick(); cur++; end
    en = 1'b0;
    while (cur < 524) begin tick(); cur++; end
    @(negedge clk);
    chk("drop_dwell", outs_a(), {24'h0, 3'b000, 4'h4, 1'b0});
    while (cur < 525) begin tick(); cur++; end
    @(negedge clk);
    chk("drop_idle_525", outs_a(), 32'h0);
    while (cur < 530) begin tick(); cur++; end
    @(negedge clk);
    chk("drop_idle_530", outs_a(), 32'h0);
    while (cur < 540) begin tick(); cur++; end
    en = 1'b1;
    while (cur < 541) begin tick(); cur++; end
    @(negedge clk);
    chk("resume_load", outs_a(), 32'h0);
    while (cur < 608) begin tick(); cur++; end
    @(negedge clk);
    chk("resume_idx3", outs_a(), {24'h0, 3'b000, 4'h8, 1'b0});

    // One-digit instance: 35-cycle period, enable lit for exactly the frame_done cycle.
    last = -1; nfd = 0; nden = 0; nco = 0;
    for (int i = 0; i < 140; i++) begin
      tick();
      @(negedge clk);
      if (if_b.frame_done) begin
        if (last >= 0) chk("b_period", i - last, 35);
        last = i;
        nfd++;
      end
      if (if_b.digit_en[0]) begin
        nden++;
        if (if_b.frame_done) nco++;
      end
    end
    chk("b_fd_count", nfd, 4);
    chk("b_den_count", nden, 4);
    chk("b_den_with_fd", nco, 4);

    // Randomised traffic; the negedge monitor does the checking.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) en = ~en;
      blank_a = ($urandom_range(0, 7) == 0);
      blank_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) begin
        seg_a = {$urandom, $urandom};
        seg_b = 16'($urandom);
      end
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
